// File: rtl/ucode_pkg.sv
// Shared constants for the microcoded sequencer: control-word layout, opcodes, FSM states.
package ucode_pkg;

    localparam int unsigned CW_W = 16;

    localparam int unsigned B_HLT = 15;
    localparam int unsigned B_MI  = 14;
    localparam int unsigned B_RI  = 13;
    localparam int unsigned B_RO  = 12;
    localparam int unsigned B_IO  = 11;
    localparam int unsigned B_II  = 10;
    localparam int unsigned B_AI  = 9;
    localparam int unsigned B_AO  = 8;
    localparam int unsigned B_EO  = 7;
    localparam int unsigned B_SU  = 6;
    localparam int unsigned B_BI  = 5;
    localparam int unsigned B_OI  = 4;
    localparam int unsigned B_CE  = 3;
    localparam int unsigned B_CO  = 2;
    localparam int unsigned B_J   = 1;
    localparam int unsigned B_FI  = 0;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    function automatic logic [CW_W-1:0] cw(input int unsigned b);
        return CW_W'(1) << b;
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// Combinational microcode table: (step, op, flags) -> control word plus end-of-instruction marker.
module ucode_rom
    import ucode_pkg::*;
#(
    parameter int unsigned STEP_W = 3
) (
    input  logic [STEP_W-1:0] step,
    input  logic [3:0]        op,
    input  logic [1:0]        flags,
    output logic              last,
    output logic [CW_W-1:0]   ctrl_raw
);

    logic [3:0] t;

    always_comb begin
        t        = 4'(step);
        ctrl_raw = '0;
        last     = 1'b0;
        case (t)
            4'd0: ctrl_raw = cw(B_CO) | cw(B_MI);
            4'd1: ctrl_raw = cw(B_RO) | cw(B_II) | cw(B_CE);
            4'd2: begin
                last = 1'b1;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_raw = cw(B_IO) | cw(B_MI);
                        last     = 1'b0;
                    end
                    OP_LDI: ctrl_raw = cw(B_IO) | cw(B_AI);
                    OP_JMP: ctrl_raw = cw(B_IO) | cw(B_J);
                    OP_JC:  ctrl_raw = flags[1] ? (cw(B_IO) | cw(B_J)) : '0;
                    OP_JZ:  ctrl_raw = flags[0] ? (cw(B_IO) | cw(B_J)) : '0;
                    OP_OUT: ctrl_raw = cw(B_AO) | cw(B_OI);
                    OP_HLT: ctrl_raw = cw(B_HLT);
                    default: ctrl_raw = '0;
                endcase
            end
            4'd3: begin
                case (op)
                    OP_LDA: begin
                        ctrl_raw = cw(B_RO) | cw(B_AI);
                        last     = 1'b1;
                    end
                    OP_ADD, OP_SUB: ctrl_raw = cw(B_RO) | cw(B_BI);
                    OP_STA: begin
                        ctrl_raw = cw(B_AO) | cw(B_RI);
                        last     = 1'b1;
                    end
                    default: ctrl_raw = '0;
                endcase
            end
            4'd4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    ctrl_raw = cw(B_EO) | cw(B_AI) | cw(B_FI) | ((op == OP_SUB) ? cw(B_SU) : '0);
                    last     = 1'b1;
                end
            end
            default: ctrl_raw = '0;
        endcase
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcoded control sequencer: step counter, RUN/HALT state, latched C/Z flags, single-step gating.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 5,
    parameter bit          EARLY_END = 1'b1,
    localparam int unsigned STEP_W   = $clog2(MAX_STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        op,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic              resume,
    output logic [CW_W-1:0]   ctrl,
    output logic [STEP_W-1:0] step,
    output logic              halted,
    output logic [1:0]        flags
);

    state_t          state, state_nx;
    logic            active;
    logic            rom_last;
    logic [CW_W-1:0] ctrl_raw;

    ucode_rom #(.STEP_W(STEP_W)) u_rom (
        .step     (step),
        .op       (op),
        .flags    (flags),
        .last     (rom_last),
        .ctrl_raw (ctrl_raw)
    );

    assign active = (state == RUN) && (!step_mode || step_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:  if (active && ctrl_raw[B_HLT]) state_nx = HALT;
            HALT: if (resume) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // ROM output is masked during reset so nothing loads while rst is held.
    always_comb begin
        halted = (state == HALT);
        ctrl   = (active && !rst) ? ctrl_raw : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step  <= '0;
            flags <= 2'b00;
        end else if (active) begin
            if (ctrl_raw[B_HLT] || (EARLY_END && rom_last) || step == STEP_W'(MAX_STEPS - 1))
                step <= '0;
            else
                step <= step + 1'b1;
            if (ctrl_raw[B_FI])
                flags <= {alu_c, alu_z};
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed scoreboard bench for ucode_sequencer (default build and MAX_STEPS=7 / EARLY_END=0 build).
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op, op2;
    logic        alu_c, alu_z;
    logic        step_mode, step_req, resume;
    logic        step_mode2, step_req2, resume2;
    logic [15:0] ctrl, ctrl2;
    logic [2:0]  step, step2;
    logic        halted, halted2;
    logic [1:0]  flags, flags2;

    int tests = 0;
    int fails = 0;
    bit sel2  = 1'b0;

    typedef struct {
        string       tag;
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic        halted;
    } exp_t;
    exp_t sb[$];

    ucode_sequencer #(.MAX_STEPS(5), .EARLY_END(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .alu_c(alu_c), .alu_z(alu_z),
        .step_mode(step_mode), .step_req(step_req), .resume(resume),
        .ctrl(ctrl), .step(step), .halted(halted), .flags(flags)
    );

    ucode_sequencer #(.MAX_STEPS(7), .EARLY_END(1'b0)) dut2 (
        .clk(clk), .rst(rst), .op(op2), .alu_c(alu_c), .alu_z(alu_z),
        .step_mode(step_mode2), .step_req(step_req2), .resume(resume2),
        .ctrl(ctrl2), .step(step2), .halted(halted2), .flags(flags2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Drive phase pushes the expectation; sample point mid-cycle pops and compares.
    task automatic cyc(input string tag, input logic [15:0] c, input logic [2:0] s, input logic h);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.step = s; e.halted = h;
        sb.push_back(e);
        #3;
        if (sb.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".ctrl"},   sel2 ? ctrl2   : ctrl,   e.ctrl);
            chk({e.tag, ".step"},   sel2 ? step2   : step,   16'(e.step));
            chk({e.tag, ".halted"}, sel2 ? halted2 : halted, 16'(e.halted));
        end
        tick();
    endtask

    task automatic fetch(input string tag);
        cyc({tag, ".T0"}, 16'h4004, 3'd0, 1'b0);
        cyc({tag, ".T1"}, 16'h1408, 3'd1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; op = 4'd0; op2 = 4'd5; alu_c = 1'b0; alu_z = 1'b0;
        step_mode = 1'b0; step_req = 1'b0; resume = 1'b0;
        step_mode2 = 1'b1; step_req2 = 1'b0; resume2 = 1'b0;
        tick(); tick();
        chk("rst.ctrl", ctrl, 16'h0000);
        chk("rst.step", 16'(step), 16'h0);
        chk("rst.flags", 16'(flags), 16'h0);
        chk("rst.halted", 16'(halted), 16'h0);
        rst = 1'b0;

        // ADD with C=1 Z=0
        op = 4'd2; alu_c = 1'b1; alu_z = 1'b0;
        fetch("add");
        cyc("add.T2", 16'h4800, 3'd2, 1'b0);
        cyc("add.T3", 16'h1020, 3'd3, 1'b0);
        cyc("add.T4", 16'h0281, 3'd4, 1'b0);
        chk("add.flags", 16'(flags), 16'h2);
        chk("add.step0", 16'(step), 16'h0);

        op = 4'd7; fetch("jc1");
        cyc("jc1.T2", 16'h0802, 3'd2, 1'b0);
        op = 4'd8; fetch("jz0");
        cyc("jz0.T2", 16'h0000, 3'd2, 1'b0);

        // SUB with C=0 Z=1
        op = 4'd3; alu_c = 1'b0; alu_z = 1'b1;
        fetch("sub");
        cyc("sub.T2", 16'h4800, 3'd2, 1'b0);
        cyc("sub.T3", 16'h1020, 3'd3, 1'b0);
        cyc("sub.T4", 16'h02C1, 3'd4, 1'b0);
        chk("sub.flags", 16'(flags), 16'h1);
        alu_c = 1'b1; alu_z = 1'b0;

        op = 4'd8; fetch("jz1");
        cyc("jz1.T2", 16'h0802, 3'd2, 1'b0);
        op = 4'd7; fetch("jc0");
        cyc("jc0.T2", 16'h0000, 3'd2, 1'b0);
        chk("jc0.step0", 16'(step), 16'h0);

        op = 4'd0;  fetch("nop"); cyc("nop.T2", 16'h0000, 3'd2, 1'b0);
        op = 4'd5;  fetch("ldi"); cyc("ldi.T2", 16'h0A00, 3'd2, 1'b0);
        op = 4'd4;  fetch("sta");
        cyc("sta.T2", 16'h4800, 3'd2, 1'b0);
        cyc("sta.T3", 16'h2100, 3'd3, 1'b0);
        op = 4'd14; fetch("out"); cyc("out.T2", 16'h0110, 3'd2, 1'b0);
        op = 4'd6;  fetch("jmp"); cyc("jmp.T2", 16'h0802, 3'd2, 1'b0);
        op = 4'd10; resume = 1'b1; step_req = 1'b1;
        fetch("op10"); cyc("op10.T2", 16'h0000, 3'd2, 1'b0);
        resume = 1'b0; step_req = 1'b0;
        chk("flags.held", 16'(flags), 16'h1);

        op = 4'd15; fetch("hlt");
        cyc("hlt.T2", 16'h8000, 3'd2, 1'b0);
        for (int i = 0; i < 10; i++) cyc("hlt.idle", 16'h0000, 3'd0, 1'b1);
        resume = 1'b1;
        cyc("hlt.resume", 16'h0000, 3'd0, 1'b1);
        resume = 1'b0; op = 4'd1;
        cyc("hlt.after", 16'h4004, 3'd0, 1'b0);
        cyc("hlt.after.T1", 16'h1408, 3'd1, 1'b0);
        cyc("lda.T2", 16'h4800, 3'd2, 1'b0);
        cyc("lda.T3", 16'h1200, 3'd3, 1'b0);

        // single-step LDA: one request every 4th cycle
        step_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] want;
            case (k)
                0: want = 16'h4004;
                1: want = 16'h1408;
                2: want = 16'h4800;
                default: want = 16'h1200;
            endcase
            step_req = 1'b0;
            for (int j = 0; j < 3; j++) cyc("ss.stall", 16'h0000, 3'(k), 1'b0);
            step_req = 1'b1;
            cyc("ss.req", want, 3'(k), 1'b0);
        end
        step_req = 1'b0;
        chk("ss.done", 16'(step), 16'h0);
        cyc("ss.stall2", 16'h0000, 3'd0, 1'b0);
        step_req = 1'b1;
        cyc("ss.T0", 16'h4004, 3'd0, 1'b0);
        step_req = 1'b0; step_mode = 1'b0;
        cyc("mode.T1", 16'h1408, 3'd1, 1'b0);
        cyc("mode.T2", 16'h4800, 3'd2, 1'b0);
        chk("mode.flags", 16'(flags), 16'h1);

        // reset mid-instruction
        chk("pre.rst.step", 16'(step), 16'h3);
        rst = 1'b1; #1;
        chk("mid.rst.ctrl", ctrl, 16'h0000);
        chk("mid.rst.step", 16'(step), 16'h0);
        chk("mid.rst.flags", 16'(flags), 16'h0);
        tick();
        chk("mid.rst.ctrl2", ctrl, 16'h0000);
        rst = 1'b0;
        cyc("rel.T0", 16'h4004, 3'd0, 1'b0);

        // MAX_STEPS=7, EARLY_END=0: LDI runs all steps then wraps
        sel2 = 1'b1; step_mode2 = 1'b0;
        fetch("ldi7");
        cyc("ldi7.T2", 16'h0A00, 3'd2, 1'b0);
        for (int s = 3; s < 7; s++) cyc("ldi7.pad", 16'h0000, 3'(s), 1'b0);
        cyc("ldi7.wrap", 16'h4004, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
